rapcla_recon_ctrl: RTL and testbench

RAPCLA_RECON_CTRL -- requirements
Module: rapcla_recon_ctrl

---
 rtl/rapcla_pkg.sv | 15 +
 rtl/rapcla_level_fsm.sv | 89 ++++++++
 rtl/rapcla_recon_ctrl.sv | 169 ++++++++++++++++
 tb/tb_rapcla_recon_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rapcla_pkg.sv
// Shared types and default parameters for the reconfigurable approximate-adder controller.
package rapcla_pkg;

    localparam int unsigned SIZE_DEF       = 16;
    localparam int unsigned GROUPSIZE_DEF  = 8;
    localparam int unsigned EVAL_LEN_DEF   = 16;
    localparam int unsigned ERR_THRESH_DEF = 2;

    typedef enum logic [1:0] {
        S_EXACT  = 2'd0,
        S_MIXED  = 2'd1,
        S_APPROX = 2'd2
    } rapcla_state_e;

endpackage

// File: rtl/rapcla_level_fsm.sv
// Evaluation-window bookkeeping: counts samples and mismatches, then raises or lowers
// the approximation level at the end of each window.
module rapcla_level_fsm
    import rapcla_pkg::*;
#(
    parameter int unsigned NG         = SIZE_DEF / GROUPSIZE_DEF,
    parameter int unsigned EVAL_LEN   = EVAL_LEN_DEF,
    parameter int unsigned ERR_THRESH = ERR_THRESH_DEF,
    localparam int unsigned LW        = $clog2(NG + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          xfer_i,
    input  logic          err_i,
    output logic [LW-1:0] level_o,
    output rapcla_state_e state_o
);

    localparam int unsigned WW = $clog2(EVAL_LEN + 1);
    localparam int unsigned MW = $clog2(ERR_THRESH + 2);

    localparam logic [WW-1:0] WIN_LAST = WW'(EVAL_LEN - 1);
    localparam logic [MW-1:0] MIS_SAT  = MW'(ERR_THRESH + 1);
    localparam logic [MW-1:0] MIS_THR  = MW'(ERR_THRESH);
    localparam logic [LW-1:0] LVL_MAX  = LW'(NG);

    logic [LW-1:0] level_q, level_d;
    logic [WW-1:0] win_q, win_d;
    logic [MW-1:0] mis_q, mis_d;
    logic [MW-1:0] mis_inc;
    rapcla_state_e state_q, state_d;

    always_comb begin
        level_d = level_q;
        win_d   = win_q;
        mis_d   = mis_q;
        mis_inc = mis_q;
        state_d = state_q;

        if (xfer_i) begin
            // The decision must include the sample completing the window.
            if (err_i && (mis_q != MIS_SAT)) begin
                mis_inc = mis_q + MW'(1);
            end
            if (win_q == WIN_LAST) begin
                win_d = '0;
                mis_d = '0;
                if (mis_inc > MIS_THR) begin
                    if (level_q != '0) begin
                        level_d = level_q - LW'(1);
                    end
                end else if (mis_inc == '0) begin
                    if (level_q != LVL_MAX) begin
                        level_d = level_q + LW'(1);
                    end
                end
            end else begin
                win_d = win_q + WW'(1);
                mis_d = mis_inc;
            end
        end

        if (level_d == '0) begin
            state_d = S_EXACT;
        end else if (level_d == LVL_MAX) begin
            state_d = S_APPROX;
        end else begin
            state_d = S_MIXED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            win_q   <= '0;
            mis_q   <= '0;
            state_q <= S_EXACT;
        end else begin
            level_q <= level_d;
            win_q   <= win_d;
            mis_q   <= mis_d;
            state_q <= state_d;
        end
    end

    assign level_o = level_q;
    assign state_o = state_q;

endmodule

// File: rtl/rapcla_recon_ctrl.sv
// Two-stage operand/result pipeline around an external approximate adder with adaptive
// per-group approximation. Optional err_total counter enabled by RAPCLA_ERR_TOTAL_EN.
module rapcla_recon_ctrl
    import rapcla_pkg::*;
#(
    parameter int unsigned SIZE       = SIZE_DEF,
    parameter int unsigned GROUPSIZE  = GROUPSIZE_DEF,
    parameter int unsigned EVAL_LEN   = EVAL_LEN_DEF,
    parameter int unsigned ERR_THRESH = ERR_THRESH_DEF,
    localparam int unsigned NG        = SIZE / GROUPSIZE,
    localparam int unsigned LW        = $clog2(NG + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [SIZE-1:0] in_a_i,
    input  logic [SIZE-1:0] in_b_i,
    input  logic            in_cin_i,
    output logic [SIZE-1:0] add_a_o,
    output logic [SIZE-1:0] add_b_o,
    output logic            add_cin_o,
    output logic [NG-1:0]   add_recon_o,
    input  logic [SIZE-1:0] add_sum_i,
    input  logic            add_cout_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [SIZE-1:0] out_sum_o,
    output logic            out_cout_o,
    output logic            out_err_o,
`ifdef RAPCLA_ERR_TOTAL_EN
    output logic [15:0]     err_total_o,
`endif
    output logic [LW-1:0]   level_o
);

    logic            s1_valid_q, s1_valid_d;
    logic [SIZE-1:0] a_q, a_d, b_q, b_d;
    logic            cin_q, cin_d;
    logic            s2_valid_q, s2_valid_d;
    logic [SIZE-1:0] sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            err_q, err_d;

    logic            s1_xfer;
    logic            accept;
    logic [SIZE:0]   exact_sum;
    logic            sample_err;
    logic [LW-1:0]   level;
    rapcla_state_e   state;

    assign s1_xfer    = s1_valid_q && (!s2_valid_q || out_ready_i);
    assign in_ready_o = !s1_valid_q || s1_xfer;
    assign accept     = in_valid_i && in_ready_o;

    assign exact_sum  = {1'b0, a_q} + {1'b0, b_q} + {{SIZE{1'b0}}, cin_q};
    assign sample_err = exact_sum != {add_cout_i, add_sum_i};

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        s2_valid_d = s2_valid_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        err_d      = err_q;

        if (s1_xfer) begin
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            a_d        = in_a_i;
            b_d        = in_b_i;
            cin_d      = in_cin_i;
        end

        if (s1_xfer) begin
            s2_valid_d = 1'b1;
            sum_d      = add_sum_i;
            cout_d     = add_cout_i;
            err_d      = sample_err;
        end else if (out_ready_i) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            s2_valid_q <= s2_valid_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            err_q      <= err_d;
        end
    end

    rapcla_level_fsm #(
        .NG         (NG),
        .EVAL_LEN   (EVAL_LEN),
        .ERR_THRESH (ERR_THRESH)
    ) u_level_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .xfer_i  (s1_xfer),
        .err_i   (sample_err),
        .level_o (level),
        .state_o (state)
    );

    // Recon is derived from the registered level, so a new level only reaches the adder
    // after the window-closing edge.
    always_comb begin
        add_recon_o = '0;
        case (state)
            S_EXACT:  add_recon_o = '0;
            S_APPROX: add_recon_o = '1;
            default: begin
                for (int g = 0; g < NG; g++) begin
                    add_recon_o[g] = LW'(g) < level;
                end
            end
        endcase
    end

`ifdef RAPCLA_ERR_TOTAL_EN
    logic [15:0] err_total_q, err_total_d;

    always_comb begin
        err_total_d = err_total_q;
        if (s1_xfer && sample_err && (err_total_q != 16'hFFFF)) begin
            err_total_d = err_total_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_total_q <= '0;
        end else begin
            err_total_q <= err_total_d;
        end
    end

    assign err_total_o = err_total_q;
`endif

    assign add_a_o     = a_q;
    assign add_b_o     = b_q;
    assign add_cin_o   = cin_q;
    assign out_valid_o = s2_valid_q;
    assign out_sum_o   = sum_q;
    assign out_cout_o  = cout_q;
    assign out_err_o   = err_q;
    assign level_o     = level;

endmodule

// File: tb/tb_rapcla_recon_ctrl.sv
// Scoreboard bench for rapcla_recon_ctrl; the adder model corrupts sum bit 0 whenever
// the operand A carries the 0xE5 marker in its upper byte.
module tb_rapcla_recon_ctrl;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [1:0]  add_recon;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_err;
    logic [1:0]  level;
`ifdef RAPCLA_ERR_TOTAL_EN
    logic [15:0] err_total;
`endif

    int   checks;
    int   errors;
    int   stall_cnt;
    exp_t sb_q[$];
    exp_t mon_e;

    logic [16:0] model_sum;
    logic        model_inj;

    assign model_sum = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
    assign model_inj = add_a[15:8] == 8'hE5;
    assign add_sum   = model_sum[15:0] ^ {15'd0, model_inj};
    assign add_cout  = model_sum[16];

    rapcla_recon_ctrl #(
        .SIZE       (16),
        .GROUPSIZE  (8),
        .EVAL_LEN   (16),
        .ERR_THRESH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .in_cin_i    (in_cin),
        .add_a_o     (add_a),
        .add_b_o     (add_b),
        .add_cin_o   (add_cin),
        .add_recon_o (add_recon),
        .add_sum_i   (add_sum),
        .add_cout_i  (add_cout),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_sum_o   (out_sum),
        .out_cout_o  (out_cout),
        .out_err_o   (out_err),
`ifdef RAPCLA_ERR_TOTAL_EN
        .err_total_o (err_total),
`endif
        .level_o     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got sum=%h cout=%b err=%b, required no output",
                         out_sum, out_cout, out_err);
            end else begin
                mon_e = sb_q.pop_front();
                if ({out_sum, out_cout, out_err} !== {mon_e.sum, mon_e.cout, mon_e.err}) begin
                    errors++;
                    $display("FAIL sb_result: got sum=%h cout=%b err=%b, required sum=%h cout=%b err=%b",
                             out_sum, out_cout, out_err, mon_e.sum, mon_e.cout, mon_e.err);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] e17;
        exp_t        e;
        int          n;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        n        = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            stall_cnt++;
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
            in_valid = 1'b0;
            return;
        end
        e17    = {1'b0, a} + {1'b0, b} + {16'd0, cin};
        e.sum  = e17[15:0] ^ {15'd0, (a[15:8] == 8'hE5)};
        e.cout = e17[16];
        e.err  = a[15:8] == 8'hE5;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d samples outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_level(input string name, input logic [1:0] exp_lvl,
                               input logic [1:0] exp_recon);
        checks += 2;
        if (level !== exp_lvl) begin
            errors++;
            $display("FAIL %s_level: got %0d, required %0d", name, level, exp_lvl);
        end
        if (add_recon !== exp_recon) begin
            errors++;
            $display("FAIL %s_recon: got %b, required %b", name, add_recon, exp_recon);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        @(negedge clk);
        checks += 2;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        check_level("reset", 2'd0, 2'b00);
        sync();
    endtask

    task automatic test_carry();
        send(16'hFFFF, 16'h0001, 1'b0);
        idle();
        drain();
        check_level("carry", 2'd0, 2'b00);
        sync();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) send(16'h0001, 16'h0002, 1'b0);
        idle();
        drain();
        check_level("fill1", 2'd1, 2'b01);
        sync();
        for (int i = 0; i < 16; i++) send(16'h0001, 16'h0002, 1'b0);
        idle();
        drain();
        check_level("fill2", 2'd2, 2'b11);
        sync();
    endtask

    task automatic test_errors();
        logic [15:0] a;
        for (int i = 0; i < 16; i++) begin
            a = (i == 3 || i == 9) ? (16'hE500 | 16'(i)) : 16'(i);
            send(a, 16'(i * 3), 1'(i));
        end
        idle();
        drain();
        check_level("err2_hold", 2'd2, 2'b11);
        sync();
        for (int i = 0; i < 16; i++) begin
            a = (i == 1 || i == 7 || i == 12) ? (16'hE500 | 16'(i)) : 16'(i + 100);
            send(a, 16'(i * 5), 1'b0);
        end
        idle();
        drain();
        check_level("err3_dec", 2'd1, 2'b01);
        sync();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0);
        send(16'h3333, 16'h4444, 1'b1);
        idle();
        @(negedge clk);
        checks += 3;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready: got %b, required 0", in_ready);
        end
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_out_valid: got %b, required 1", out_valid);
        end
        if (out_sum !== 16'h3333) begin
            errors++;
            $display("FAIL bp_out_sum: got %h, required 3333", out_sum);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (out_sum !== 16'h3333 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: got sum=%h valid=%b, required sum=3333 valid=1",
                     out_sum, out_valid);
        end
        sync();
        out_ready = 1'b1;
        drain();
        sync();
    endtask

    task automatic test_latency();
        send(16'h0100, 16'h0200, 1'b0);
        idle();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_early: out_valid got %b one cycle after accept, required 0",
                     out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 16'h0300) begin
            errors++;
            $display("FAIL lat_two: got valid=%b sum=%h, required valid=1 sum=0300",
                     out_valid, out_sum);
        end
        drain();
        sync();
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        stall_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            a = 16'($urandom);
            if (a[15:8] == 8'hE5) a = a ^ 16'h0100;
            send(a, 16'($urandom), 1'($urandom));
        end
        idle();
        checks++;
        if (stall_cnt != 0) begin
            errors++;
            $display("FAIL b2b_stalls: got %0d stall cycles, required 0", stall_cnt);
        end
        drain();
        check_level("b2b", 2'd1, 2'b01);
        sync();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(16'h0A0A, 16'h0505, 1'b0);
        send(16'h0B0B, 16'h0404, 1'b0);
        idle();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_valid: got %b, required 1", out_valid);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 3;
        if ({out_valid, out_sum, out_cout, out_err} !== 19'd0) begin
            errors++;
            $display("FAIL mid_outputs: got valid=%b sum=%h cout=%b err=%b, required all 0",
                     out_valid, out_sum, out_cout, out_err);
        end
        if ({add_a, add_b, add_cin} !== 33'd0) begin
            errors++;
            $display("FAIL mid_add_ops: got a=%h b=%h cin=%b, required all 0",
                     add_a, add_b, add_cin);
        end
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_in_ready: got %b, required 1", in_ready);
        end
        check_level("mid_rst", 2'd0, 2'b00);
        sb_q.delete();
        sync();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        sync();
        // Five clean samples would close a stale window had it survived the reset.
        for (int i = 0; i < 5; i++) send(16'(i), 16'(i + 1), 1'b0);
        idle();
        drain();
        check_level("mid_window", 2'd0, 2'b00);
        sync();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        stall_cnt = 0;
        test_reset();
        test_carry();
        test_reset();
        test_fill();
        test_errors();
        test_backpressure();
        test_latency();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d outstanding, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
